// File: rtl/display_pkg.sv
// Shared widths, FSM encoding and defaults for the display pixel datapath.
package display_pkg;

    localparam int TIMING_W = 10;
    localparam int PIXEL_W  = 8;
    localparam int WORD_W   = 32;
    localparam int FIDX_W   = 16;

    localparam logic [PIXEL_W-1:0] BLANK_PIXEL_DEF = 8'h00;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        COMPOSE = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/display_datapath_if.sv
// Pixel input, timing configuration and frame readout bundle of the display datapath.
interface display_datapath_if;
    import display_pkg::*;

    logic [WORD_W-1:0]   WData;
    logic [TIMING_W-1:0] HBOut_PD;
    logic [TIMING_W-1:0] VBOut_PD;
    logic [TIMING_W-1:0] AIPOut_PD;
    logic [TIMING_W-1:0] AILOut_PD;
    logic                CSDisplay;
    logic                readFrame;
    logic [FIDX_W-1:0]   FrameWInd;
    logic [PIXEL_W-1:0]  FrameDataOut;

    modport master (
        output WData, HBOut_PD, VBOut_PD, AIPOut_PD, AILOut_PD,
        output CSDisplay, readFrame, FrameWInd,
        input  FrameDataOut
    );

    modport slave (
        input  WData, HBOut_PD, VBOut_PD, AIPOut_PD, AILOut_PD,
        input  CSDisplay, readFrame, FrameWInd,
        output FrameDataOut
    );

endinterface

// File: rtl/display_frame_ram.sv
// Byte RAM: one write port, one registered read port. Out-of-range or
// disabled reads return 0; contents are never cleared by reset.
module display_frame_ram #(
    parameter int unsigned DEPTH = 65536,
    parameter int          AW    = 16,
    parameter int          DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];

    // Write port; addresses past the end are silently ignored.
    always_ff @(posedge clk) begin
        if (we && (32'(waddr) < DEPTH))
            mem[waddr[IW-1:0]] <= wdata;
    end

    // Registered read; zero when disabled, out of range or in reset.
    always_ff @(posedge clk) begin
        if (reset)
            rdata <= '0;
        else if (re && (32'(raddr) < DEPTH))
            rdata <= mem[raddr[IW-1:0]];
        else
            rdata <= '0;
    end

endmodule

// File: rtl/display_datapath.sv
// Display pixel datapath: buffers incoming pixels, composes a blanked frame
// into a byte frame memory, and serves indexed frame readout.
module display_datapath
    import display_pkg::*;
#(
    parameter int unsigned         BUF_DEPTH   = 16384,
    parameter int unsigned         FRAME_DEPTH = 65536,
    parameter logic [PIXEL_W-1:0]  BLANK_PIXEL = BLANK_PIXEL_DEF
) (
    input logic               clk,
    input logic               reset,
    display_datapath_if.slave bus
);
    localparam int PW = $clog2(BUF_DEPTH) + 1;
    localparam int CW = TIMING_W + 1;

    state_t state, state_nxt;

    logic [PW-1:0]         wptr, rptr;
    logic [CW-1:0]         pix, line;
    logic [FIDX_W-1:0]     faddr, faddr_d;
    logic [TIMING_W-1:0]   hb, vb, aip, ail;
    logic [2*TIMING_W-1:0] fill_total;
    logic [CW-1:0]         line_len, nlines;
    logic                  buf_full, size_zero, last_byte, active;
    logic                  buf_we, compose_go, buf_re;
    logic                  wr_vld, act_d;
    logic [PIXEL_W-1:0]    buf_rdata;
    logic                  unused_wdata;

    assign unused_wdata = ^bus.WData[WORD_W-1:PIXEL_W];

    assign fill_total = bus.AIPOut_PD * bus.AILOut_PD;
    assign buf_full   = 32'(wptr) >= 32'(fill_total);
    assign line_len   = CW'(hb) + CW'(aip);
    assign nlines     = CW'(vb) + CW'(ail);
    assign size_zero  = (line_len == '0) || (nlines == '0);
    assign last_byte  = (pix == line_len - CW'(1)) && (line == nlines - CW'(1));
    assign active     = (line >= CW'(vb)) && (pix >= CW'(hb));
    assign buf_re     = compose_go && active;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= FILL;
        else       state <= state_nxt;
    end

    // Next state: chip-select drives fill/compose, last byte ends compose.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (bus.CSDisplay) state_nxt = COMPOSE;
            COMPOSE: if (!bus.CSDisplay) state_nxt = FILL;
                     else if (size_zero || last_byte) state_nxt = DONE;
            DONE:    if (!bus.CSDisplay) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // State outputs: buffer write strobe and per-cycle compose enable.
    always_comb begin
        buf_we     = 1'b0;
        compose_go = 1'b0;
        case (state)
            FILL:    buf_we = !bus.CSDisplay && !bus.readFrame && !buf_full;
            COMPOSE: compose_go = bus.CSDisplay && !size_zero;
            default: ;
        endcase
    end

    // Pointers, raster counters and timing latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            pix   <= '0;
            line  <= '0;
            faddr <= '0;
            hb    <= '0;
            vb    <= '0;
            aip   <= '0;
            ail   <= '0;
        end else begin
            if (buf_we) wptr <= wptr + PW'(1);
            if (state == FILL && bus.CSDisplay) begin
                hb    <= bus.HBOut_PD;
                vb    <= bus.VBOut_PD;
                aip   <= bus.AIPOut_PD;
                ail   <= bus.AILOut_PD;
                rptr  <= '0;
                pix   <= '0;
                line  <= '0;
                faddr <= '0;
            end
            if (compose_go) begin
                faddr <= faddr + FIDX_W'(1);
                if (active) rptr <= rptr + PW'(1);
                if (pix == line_len - CW'(1)) begin
                    pix  <= '0;
                    line <= line + CW'(1);
                end else begin
                    pix <= pix + CW'(1);
                end
            end
            if (state == COMPOSE && state_nxt == DONE) wptr <= '0;
        end
    end

    // Frame write lags compose by one cycle to meet the registered buffer read;
    // the final byte therefore lands in the first DONE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_vld  <= 1'b0;
            act_d   <= 1'b0;
            faddr_d <= '0;
        end else begin
            wr_vld  <= compose_go;
            act_d   <= active;
            faddr_d <= faddr;
        end
    end

    display_frame_ram #(.DEPTH(BUF_DEPTH), .AW(PW), .DW(PIXEL_W)) u_buf (
        .clk   (clk),
        .reset (reset),
        .we    (buf_we),
        .waddr (wptr),
        .wdata (bus.WData[PIXEL_W-1:0]),
        .re    (buf_re),
        .raddr (rptr),
        .rdata (buf_rdata)
    );

    display_frame_ram #(.DEPTH(FRAME_DEPTH), .AW(FIDX_W), .DW(PIXEL_W)) u_frame (
        .clk   (clk),
        .reset (reset),
        .we    (wr_vld),
        .waddr (faddr_d),
        .wdata (act_d ? buf_rdata : BLANK_PIXEL),
        .re    (bus.readFrame),
        .raddr (bus.FrameWInd),
        .rdata (bus.FrameDataOut)
    );

endmodule

// File: tb/tb_display_datapath.sv
// Self-checking bench for display_datapath: fill, compose, readout, abort, reset.
module tb_display_datapath;
    import display_pkg::*;

    localparam int FD  = 12100;
    localparam int AIP = 100;
    localparam int AIL = 100;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    display_datapath_if bus();

    display_datapath #(.BUF_DEPTH(16384), .FRAME_DEPTH(FD), .BLANK_PIXEL(8'h00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] buf_m   [16384];
    logic [7:0] frame_m [FD];
    logic [7:0] exp_q   [$];
    int checks = 0;
    int errors = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Compose model: bytes [0, nbytes) of a frame with the given blanking.
    task automatic model_compose(input int hb, input int vb, input int nbytes);
        int len, ln, px;
        len = hb + AIP;
        for (int b = 0; b < nbytes; b++) begin
            ln = b / len;
            px = b % len;
            if (ln < vb || px < hb) frame_m[b] = 8'h00;
            else                    frame_m[b] = buf_m[(ln - vb) * AIP + (px - hb)];
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        checks++;
        if (dut.state !== FILL) begin
            errors++;
            $display("FAIL reset_state: got %0d expected %0d", dut.state, FILL);
        end
        checks++;
        if (dut.wptr !== '0) begin
            errors++;
            $display("FAIL reset_wptr: got %0d expected 0", dut.wptr);
        end
        checks++;
        if (bus.FrameDataOut !== 8'h00) begin
            errors++;
            $display("FAIL reset_dout: got %0h expected 0", bus.FrameDataOut);
        end
        reset = 1'b0;
    endtask

    // Fill n words of pattern i*mul+add; readFrame held on the entry cycle
    // so the state transition itself writes nothing.
    task automatic test_fill(input int n, input int mul, input int add);
        bus.CSDisplay = 1'b0;
        bus.readFrame = 1'b1;
        tick();
        bus.readFrame = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.WData = 32'(i * mul + add);
            if (i < AIP * AIL) buf_m[i] = bus.WData[7:0];
            tick();
        end
        checks++;
        if (int'(dut.wptr) != AIP * AIL) begin
            errors++;
            $display("FAIL fill_wptr_sat: got %0d expected %0d", dut.wptr, AIP * AIL);
        end
    endtask

    task automatic test_compose;
        bus.HBOut_PD  = 10'd10;
        bus.VBOut_PD  = 10'd10;
        bus.CSDisplay = 1'b1;
        tick();
        repeat (FD - 1) tick();
        checks++;
        if (dut.state !== COMPOSE) begin
            errors++;
            $display("FAIL compose_len_early: got %0d expected %0d", dut.state, COMPOSE);
        end
        tick();
        checks++;
        if (dut.state !== DONE) begin
            errors++;
            $display("FAIL compose_done: got %0d expected %0d", dut.state, DONE);
        end
        checks++;
        if (dut.wptr !== '0) begin
            errors++;
            $display("FAIL compose_wptr_clr: got %0d expected 0", dut.wptr);
        end
        model_compose(10, 10, FD);
    endtask

    // Scoreboard readout: expected byte queued with the index, popped one cycle later.
    task automatic test_readout(input int lo, input int hi);
        logic [7:0] e;
        bus.readFrame = 1'b1;
        for (int idx = lo; idx <= hi; idx++) begin
            bus.FrameWInd = 16'(idx);
            exp_q.push_back(frame_m[idx]);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (bus.FrameDataOut !== e) begin
                errors++;
                $display("FAIL readout[%0d]: got %0h expected %0h", idx, bus.FrameDataOut, e);
            end
        end
    endtask

    task automatic test_read_gating;
        logic [7:0] e;
        bus.readFrame = 1'b1;
        bus.FrameWInd = 16'd1111;
        exp_q.push_back(frame_m[1111]);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (bus.FrameDataOut !== e) begin
            errors++;
            $display("FAIL read_1111: got %0h expected %0h", bus.FrameDataOut, e);
        end
        bus.readFrame = 1'b0;
        exp_q.push_back(8'h00);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (bus.FrameDataOut !== e) begin
            errors++;
            $display("FAIL read_disabled: got %0h expected %0h", bus.FrameDataOut, e);
        end
        bus.readFrame = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus.FrameWInd = (k == 0) ? 16'hFFFF : 16'(FD);
            exp_q.push_back(8'h00);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (bus.FrameDataOut !== e) begin
                errors++;
                $display("FAIL read_oob[%0h]: got %0h expected %0h", bus.FrameWInd, bus.FrameDataOut, e);
            end
        end
    endtask

    // Abort after 500 compose cycles with no blanking: only bytes 0..499 change.
    task automatic test_abort;
        test_fill(AIP * AIL, 3, 5);
        bus.HBOut_PD  = 10'd0;
        bus.VBOut_PD  = 10'd0;
        bus.CSDisplay = 1'b1;
        tick();
        repeat (500) tick();
        bus.CSDisplay = 1'b0;
        tick();
        checks++;
        if (dut.state !== FILL) begin
            errors++;
            $display("FAIL abort_state: got %0d expected %0d", dut.state, FILL);
        end
        checks++;
        if (int'(dut.wptr) != AIP * AIL) begin
            errors++;
            $display("FAIL abort_wptr_kept: got %0d expected %0d", dut.wptr, AIP * AIL);
        end
        model_compose(0, 0, 500);
        test_readout(0, 1199);
        bus.HBOut_PD = 10'd10;
        bus.VBOut_PD = 10'd10;
    endtask

    task automatic test_reset_mid_compose;
        bus.readFrame = 1'b0;
        bus.CSDisplay = 1'b1;
        tick();
        repeat (20) tick();
        checks++;
        if (dut.state !== COMPOSE) begin
            errors++;
            $display("FAIL midreset_pre_state: got %0d expected %0d", dut.state, COMPOSE);
        end
        bus.readFrame = 1'b1;
        bus.FrameWInd = 16'd1150;
        tick();
        checks++;
        if (bus.FrameDataOut !== frame_m[1150]) begin
            errors++;
            $display("FAIL read_during_compose: got %0h expected %0h", bus.FrameDataOut, frame_m[1150]);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (dut.state !== FILL) begin
            errors++;
            $display("FAIL midreset_state: got %0d expected %0d", dut.state, FILL);
        end
        checks++;
        if (dut.wptr !== '0) begin
            errors++;
            $display("FAIL midreset_wptr: got %0d expected 0", dut.wptr);
        end
        checks++;
        if (bus.FrameDataOut !== 8'h00) begin
            errors++;
            $display("FAIL midreset_dout: got %0h expected 0", bus.FrameDataOut);
        end
    endtask

    initial begin
        bus.WData     = '0;
        bus.HBOut_PD  = 10'd10;
        bus.VBOut_PD  = 10'd10;
        bus.AIPOut_PD = 10'(AIP);
        bus.AILOut_PD = 10'(AIL);
        bus.CSDisplay = 1'b0;
        bus.readFrame = 1'b0;
        bus.FrameWInd = '0;
        test_reset();
        test_fill(AIP * AIL + 50, 1, 0);
        test_compose();
        test_readout(0, FD - 1);
        test_read_gating();
        test_abort();
        test_reset_mid_compose();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_datapath.md
Name: display_datapath

Overview:
- Pixel datapath of the display adapter.
- Captures a stream of 32-bit pixel words into a line/pixel input buffer (buffer 0).
- On display chip-select, composes a full frame (active image plus horizontal/vertical blanking) into a byte-wide frame memory.
- Exposes that frame for indexed readout to an image writer.

Parameters:
- BUF_DEPTH, 16384, input-buffer entries; must be >= AIPOut_PD*AILOut_PD.
- FRAME_DEPTH, 65536, frame-memory bytes; must be >= (HB+AIP)*(VB+AIL).
- BLANK_PIXEL, 8'h00, value written to blanking positions.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- WData  in  32  incoming pixel word; pixel = WData[7:0], upper bits ignored
- HBOut_PD  in  10  horizontal blanking pixels per line
- VBOut_PD  in  10  vertical blanking lines per frame
- AIPOut_PD  in  10  active image pixels per line
- AILOut_PD  in  10  active image lines per frame
- CSDisplay  in  1  display select: 0 = fill buffer, 1 = compose frame
- readFrame  in  1  frame readout enable
- FrameWInd  in  16  frame-memory read index
- FrameDataOut  out  8  frame byte at FrameWInd

Behaviour:
- Reset (synchronous, active-high):
  - Write pointer, read pointer, line/pixel counters cleared.
  - FSM to FILL.
  - FrameDataOut = 0.
  - Memory contents not cleared.
- FSM states: FILL, COMPOSE, DONE.
- FILL (CSDisplay=0, readFrame=0):
  - Each cycle writes WData[7:0] to buffer[wptr]; wptr++.
  - When wptr reaches AIP*AIL the buffer is full; wptr saturates and further words are dropped.
  - CSDisplay=1 -> COMPOSE. Latch HB/VB/AIP/AIL on this transition; counters and rptr cleared.
- COMPOSE, one frame byte per cycle, frame address faddr from 0 upward in raster order:
  - Lines 0..VB-1: all HB+AIP bytes = BLANK_PIXEL.
  - Lines VB..VB+AIL-1: first HB bytes = BLANK_PIXEL, next AIP bytes = buffer[rptr++].
  - After the last byte (faddr = (HB+AIP)*(VB+AIL)-1) -> DONE; wptr cleared.
  - Duration is exactly (HB+AIP)*(VB+AIL) cycles.
  - CSDisplay dropping mid-compose aborts to FILL; wptr is kept and the partial frame is left as is.
- DONE: no memory writes; CSDisplay=0 -> FILL.
- Readout:
  - When readFrame=1, FrameDataOut <= frame[FrameWInd] (registered, 1-cycle latency).
  - When readFrame=0, FrameDataOut <= 0.
  - Index beyond FRAME_DEPTH-1 returns 0.
  - Readout is independent of the FSM; reading during COMPOSE returns the current memory content.
- Buffer writes are inhibited while readFrame=1, regardless of CSDisplay.
- Latched timing values are zero-safe:
  - AIP=0 or AIL=0 gives an all-blank frame.
  - A total size of 0 goes COMPOSE -> DONE in 1 cycle.
- Counter widths: line/pixel 11 bits; faddr 16 bits; rptr/wptr $clog2(BUF_DEPTH)+1 bits.

Decomposition:
- Shared package display_pkg:
  - Width constants: TIMING_W=10, PIXEL_W=8, WORD_W=32, FIDX_W=16.
  - FSM state enum (FILL, COMPOSE, DONE).
  - BLANK_PIXEL default.
- One natural sub-module: display_frame_ram, a single-port-write / single-port-read byte RAM with registered read, used for the frame memory (the input buffer can reuse it with depth BUF_DEPTH).

Test Plan:
- Reset held 1 cycle, then FILL with WData = i for i=0..9999, AIP=AIL=100 -> wptr saturates at 10000; word 10000+ dropped (check buffer[9999]=8'h0F, i.e. 9999[7:0]).
- After fill, CSDisplay=1 with HB=VB=10 -> COMPOSE lasts 12100 cycles, then DONE; frame[0..1099]=0.
- Readout after compose with readFrame=1, FrameWInd 0..12099 -> frame[1100..1109]=0, frame[1110]=8'h00 (pixel 0), frame[1111]=8'h01, frame[1209]=99[7:0]=8'h63; data appears 1 cycle after index.
- readFrame=0 with any FrameWInd -> FrameDataOut=0 next cycle; FrameWInd=16'hFFFF with FRAME_DEPTH=12100 -> 0.
- CSDisplay dropped at compose cycle 500 -> FSM back to FILL; frame[0..499] blank, no further writes.
- Reset asserted mid-COMPOSE -> next cycle FSM=FILL, wptr=0, FrameDataOut=0.
